// File: rtl/uart_bip_pkg.sv
// ============================================================================
// Module      : uart_bip_pkg
// Description : Shared opcodes, FSM state codes, reply bytes and the
//               bytes-per-field helper for the UART/BIP command loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_bip_pkg;

   localparam logic [7:0] OP_RUN   = 8'h01;
   localparam logic [7:0] OP_WR_PM = 8'h02;
   localparam logic [7:0] OP_WR_DM = 8'h03;
   localparam logic [7:0] OP_RD_DM = 8'h04;

   localparam logic [7:0] ACK_BYTE = 8'hA5;
   localparam logic [7:0] NAK_BYTE = 8'hEE;

   // Encodings are exposed on status[3:0], so they are fixed explicitly.
   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_ADDR     = 4'd1,
      ST_LEN      = 4'd2,
      ST_WDATA    = 4'd3,
      ST_WRITE    = 4'd4,
      ST_RDREQ    = 4'd5,
      ST_RDLAT    = 4'd6,
      ST_SEND     = 4'd7,
      ST_SENDWAIT = 4'd8,
      ST_RUN      = 4'd9
   } state_t;

   // Number of whole bytes needed to carry a w-bit field.
   function automatic int byte_count(input int w);
      return (w + 7) / 8;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bytes_to_word.sv
// ============================================================================
// Module      : bytes_to_word
// Description : Assembles a WIDTH-bit word from NBYTES bytes received LSB
//               first. After NBYTES loads the first byte sits in bits [7:0];
//               unused high bits of the last byte are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bytes_to_word #(
   parameter int WIDTH  = 16,
   parameter int NBYTES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [7:0]       byte_in,
   output logic [WIDTH-1:0] word
);

   logic [NBYTES*8-1:0] shreg;

   generate
      if (NBYTES == 1) begin : g_single
         // Single-byte field: the register simply captures the byte.
         always_ff @(posedge clk) begin
            if (reset)     shreg <= '0;
            else if (load) shreg <= byte_in;
         end
      end else begin : g_multi
         // New bytes enter at the top and move down, so the earliest byte ends lowest.
         always_ff @(posedge clk) begin
            if (reset)     shreg <= '0;
            else if (load) shreg <= {byte_in, shreg[NBYTES*8-1:8]};
         end
      end
   endgenerate

   assign word = shreg[WIDTH-1:0];

   generate
      if (NBYTES * 8 > WIDTH) begin : g_trim
         logic unused_high;
         assign unused_high = ^shreg[NBYTES*8-1:WIDTH];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/uart_bip_loader.sv
// ============================================================================
// Module      : uart_bip_loader
// Description : Byte-stream command decoder between a UART and the BIP core
//               memories: burst program/data writes, burst data reads, and a
//               bounded RUN with early halt. Sticky error/timeout flags.
//               Optional macro LOADER_ACK_EN: reply A5 after each write burst
//               and EE for an invalid opcode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bip_loader
   import uart_bip_pkg::*;
#(
   parameter int DATA_LENGTH = 16,
   parameter int ADDR_LENGTH = 11,
   parameter int RUN_CYCLES  = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             rx_data,
   input  logic                   rx_done,
   input  logic                   tx_done,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   output logic [ADDR_LENGTH-1:0] mem_addr,
   output logic [DATA_LENGTH-1:0] mem_wdata,
   input  logic [DATA_LENGTH-1:0] mem_rdata,
   output logic                   prog_we,
   output logic                   data_we,
   output logic                   data_re,
   input  logic                   bip_halt,
   output logic                   bip_reset,
   output logic [7:0]             status
);

   localparam int DB  = byte_count(DATA_LENGTH);
   localparam int AB  = byte_count(ADDR_LENGTH);
   localparam int RCW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

   state_t                 state, next_state;
   logic [7:0]             opcode;
   logic [7:0]             byte_cnt;
   logic [7:0]             word_cnt;
   logic [RCW-1:0]         run_cnt;
   logic [DB*8-1:0]        tx_shift;
   logic                   reply;
   logic [7:0]             reply_byte;
   logic                   err_cmd;
   logic                   run_timeout;
   logic                   addr_load;
   logic                   data_load;
   logic [ADDR_LENGTH-1:0] addr_word;
   logic                   addr_last;
   logic                   data_last;
   logic                   run_last;

   assign addr_last = (byte_cnt == 8'(AB - 1));
   assign data_last = (byte_cnt == 8'(DB - 1));
   assign run_last  = (run_cnt == RCW'(RUN_CYCLES - 1));

   bytes_to_word #(.WIDTH(ADDR_LENGTH), .NBYTES(AB)) u_addr_asm (
      .clk     (clk),
      .reset   (reset),
      .load    (addr_load),
      .byte_in (rx_data),
      .word    (addr_word)
   );

   bytes_to_word #(.WIDTH(DATA_LENGTH), .NBYTES(DB)) u_data_asm (
      .clk     (clk),
      .reset   (reset),
      .load    (data_load),
      .byte_in (rx_data),
      .word    (mem_wdata)
   );

   assign tx_data = reply ? reply_byte : tx_shift[7:0];
   assign status  = {err_cmd, run_timeout, (state != ST_IDLE), 1'b0, state};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Next-state decode and one-cycle strobes.
   always_comb begin
      next_state = state;
      addr_load  = 1'b0;
      data_load  = 1'b0;
      tx_start   = 1'b0;
      prog_we    = 1'b0;
      data_we    = 1'b0;
      data_re    = 1'b0;
      bip_reset  = 1'b1;
      case (state)
         ST_IDLE: begin
            if (rx_done) begin
               case (rx_data)
                  OP_RUN:                     next_state = ST_RUN;
                  OP_WR_PM, OP_WR_DM, OP_RD_DM: next_state = ST_ADDR;
`ifdef LOADER_ACK_EN
                  default:                    next_state = ST_SEND;
`else
                  default:                    next_state = ST_IDLE;
`endif
               endcase
            end
         end
         ST_ADDR: begin
            if (rx_done) begin
               addr_load = 1'b1;
               if (addr_last) next_state = ST_LEN;
            end
         end
         ST_LEN: begin
            if (rx_done) next_state = (opcode == OP_RD_DM) ? ST_RDREQ : ST_WDATA;
         end
         ST_WDATA: begin
            if (rx_done) begin
               data_load = 1'b1;
               if (data_last) next_state = ST_WRITE;
            end
         end
         ST_WRITE: begin
            prog_we = (opcode == OP_WR_PM);
            data_we = (opcode != OP_WR_PM);
            if (word_cnt != 8'd0) next_state = ST_WDATA;
`ifdef LOADER_ACK_EN
            else                  next_state = ST_SEND;
`else
            else                  next_state = ST_IDLE;
`endif
         end
         ST_RDREQ: begin
            data_re    = 1'b1;
            next_state = ST_RDLAT;
         end
         ST_RDLAT:  next_state = ST_SEND;
         ST_SEND: begin
            tx_start   = 1'b1;
            next_state = ST_SENDWAIT;
         end
         ST_SENDWAIT: begin
            if (tx_done) begin
               if (reply)                 next_state = ST_IDLE;
               else if (!data_last)       next_state = ST_SEND;
               else if (word_cnt != 8'd0) next_state = ST_RDREQ;
               else                       next_state = ST_IDLE;
            end
         end
         ST_RUN: begin
            bip_reset = 1'b0;
            if (bip_halt || run_last) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Datapath: counters, address, read shifter, reply byte and sticky flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         opcode      <= 8'd0;
         byte_cnt    <= 8'd0;
         word_cnt    <= 8'd0;
         run_cnt     <= '0;
         mem_addr    <= '0;
         tx_shift    <= '0;
         reply       <= 1'b0;
         reply_byte  <= 8'd0;
         err_cmd     <= 1'b0;
         run_timeout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               byte_cnt <= 8'd0;
               reply    <= 1'b0;
               run_cnt  <= '0;
               if (rx_done) begin
                  case (rx_data)
                     OP_RUN, OP_WR_PM, OP_WR_DM, OP_RD_DM: begin
                        opcode      <= rx_data;
                        err_cmd     <= 1'b0;
                        run_timeout <= 1'b0;
                     end
                     default: begin
                        err_cmd <= 1'b1;
`ifdef LOADER_ACK_EN
                        reply      <= 1'b1;
                        reply_byte <= NAK_BYTE;
`endif
                     end
                  endcase
               end
            end
            ST_ADDR, ST_WDATA: begin
               if (rx_done) byte_cnt <= ((state == ST_ADDR) ? addr_last : data_last)
                                        ? 8'd0 : byte_cnt + 8'd1;
            end
            ST_LEN: begin
               if (rx_done) begin
                  mem_addr <= addr_word;
                  word_cnt <= rx_data;
                  byte_cnt <= 8'd0;
               end
            end
            ST_WRITE: begin
               if (word_cnt != 8'd0) begin
                  word_cnt <= word_cnt - 8'd1;
                  mem_addr <= mem_addr + ADDR_LENGTH'(1);
               end
`ifdef LOADER_ACK_EN
               else begin
                  reply      <= 1'b1;
                  reply_byte <= ACK_BYTE;
               end
`endif
            end
            ST_RDLAT: begin
               tx_shift <= (DB*8)'(mem_rdata);
               byte_cnt <= 8'd0;
            end
            ST_SENDWAIT: begin
               if (tx_done && !reply) begin
                  if (!data_last) begin
                     byte_cnt <= byte_cnt + 8'd1;
                     tx_shift <= tx_shift >> 8;
                  end else if (word_cnt != 8'd0) begin
                     word_cnt <= word_cnt - 8'd1;
                     mem_addr <= mem_addr + ADDR_LENGTH'(1);
                  end
               end
            end
            ST_RUN: begin
               run_cnt <= run_cnt + RCW'(1);
               if (run_last && !bip_halt) run_timeout <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_bip_loader.sv
// ============================================================================
// Module      : tb_uart_bip_loader
// Description : Self-checking bench for uart_bip_loader with a write/tx
//               scoreboard, a paced UART model and a registered memory model.
//               Honours LOADER_ACK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_bip_loader;

   localparam int RUNC = 40;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_done = 1'b0;
   logic        tx_done = 1'b0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic [10:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'd0;
   logic        prog_we, data_we, data_re;
   logic        bip_halt = 1'b0;
   logic        bip_reset;
   logic [7:0]  status;

   typedef struct {
      logic        pm;
      logic [10:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t        wr_q[$];
   logic [7:0] tx_q[$];
   logic [15:0] mem [0:2047];

   int n_checks = 0;
   int n_pass   = 0;
   int low_cnt  = 0;
   int re_cnt   = 0;
   int tx_cnt   = 0;
   logic tx_pending = 1'b0;

   uart_bip_loader #(.DATA_LENGTH(16), .ADDR_LENGTH(11), .RUN_CYCLES(RUNC)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .tx_done   (tx_done),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .prog_we   (prog_we),
      .data_we   (data_we),
      .data_re   (data_re),
      .bip_halt  (bip_halt),
      .bip_reset (bip_reset),
      .status    (status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Registered data-memory read port.
   always @(posedge clk) begin
      if (data_re) mem_rdata <= mem[mem_addr];
   end

   // Output monitor: scoreboard pops on write strobes and transmitted bytes.
   always @(negedge clk) begin
      if (!bip_reset) low_cnt++;
      if (data_re) re_cnt++;
      if (prog_we || data_we) begin
         if (wr_q.size() == 0) check("wr_extra", wr_q.size(), 1);
         else begin
            wr_t e;
            e = wr_q.pop_front();
            check("wr_kind", {31'd0, prog_we}, {31'd0, e.pm});
            check("wr_addr", {21'd0, mem_addr}, {21'd0, e.addr});
            check("wr_data", {16'd0, mem_wdata}, {16'd0, e.data});
         end
      end
      if (tx_start) begin
         check("tx_pace", {31'd0, tx_pending}, 0);
         tx_pending = 1'b1;
         tx_cnt++;
         if (tx_q.size() == 0) check("tx_extra", tx_q.size(), 1);
         else check("tx_byte", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
      end
   end

   // UART transmitter model: answers each tx_start with tx_done a few cycles later.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_start) begin
            repeat (3) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
            tx_pending = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_data = b; rx_done = 1'b1;
      @(posedge clk);
      #1 rx_done = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic push_wr(input logic pm, input logic [10:0] a, input logic [15:0] d);
      wr_t e;
      e.pm = pm; e.addr = a; e.data = d;
      wr_q.push_back(e);
   endtask

   task automatic push_ack();
`ifdef LOADER_ACK_EN
      tx_q.push_back(8'hA5);
`endif
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (status[5] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, status[5]}, 0);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 16'(i * 3);
      mem[11'h020] = 16'hBEEF;
      mem[11'h7FF] = 16'h1234;
      mem[11'h000] = 16'hABCD;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_start", {31'd0, tx_start}, 0);
      check("rst_tx_data", {24'd0, tx_data}, 0);
      check("rst_addr", {21'd0, mem_addr}, 0);
      check("rst_wdata", {16'd0, mem_wdata}, 0);
      check("rst_strobes", {29'd0, prog_we, data_we, data_re}, 0);
      check("rst_bip_reset", {31'd0, bip_reset}, 1);
      check("rst_status", {24'd0, status}, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Program-memory burst of two words.
      push_wr(1'b1, 11'h010, 16'h55AA);
      push_wr(1'b1, 11'h011, 16'h33CC);
      push_ack();
      send_byte(8'h02); send_byte(8'h10); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'hCC); send_byte(8'h33);
      wait_idle("wrpm_idle");
      check("wrpm_drained", wr_q.size() + tx_q.size(), 0);

      // Single-word data read.
      re_cnt = 0;
      tx_q.push_back(8'hEF); tx_q.push_back(8'hBE);
      send_byte(8'h04); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
      wait_idle("rd1_idle");
      check("rd1_drained", tx_q.size(), 0);
      check("rd1_re_count", re_cnt, 1);

      // Two-word read wrapping 0x7FF -> 0x000.
      re_cnt = 0;
      tx_q.push_back(8'h34); tx_q.push_back(8'h12);
      tx_q.push_back(8'hCD); tx_q.push_back(8'hAB);
      send_byte(8'h04); send_byte(8'hFF); send_byte(8'h07); send_byte(8'h01);
      wait_idle("rd2_idle");
      check("rd2_drained", tx_q.size(), 0);
      check("rd2_re_count", re_cnt, 2);

      // RUN to timeout.
      low_cnt = 0;
      send_byte(8'h01);
      wait_idle("run_to_idle");
      check("run_to_len", low_cnt, RUNC);
      check("run_to_flag", {31'd0, status[6]}, 1);

      // RUN with halt raised in the sixth cycle.
      low_cnt = 0;
      @(posedge clk);
      #1 rx_data = 8'h01; rx_done = 1'b1;
      @(posedge clk);
      #1 rx_done = 1'b0;
      repeat (5) @(posedge clk);
      #1 bip_halt = 1'b1;
      @(posedge clk);
      #1 bip_halt = 1'b0;
      wait_idle("run_h_idle");
      check("run_h_len", low_cnt, 6);
      check("run_h_flag", {31'd0, status[6]}, 0);

      // Data-memory burst wrapping the address.
      push_wr(1'b0, 11'h7FF, 16'h1122);
      push_wr(1'b0, 11'h000, 16'h3344);
      push_ack();
      send_byte(8'h03); send_byte(8'hFF); send_byte(8'h07); send_byte(8'h01);
      send_byte(8'h22); send_byte(8'h11); send_byte(8'h44); send_byte(8'h33);
      wait_idle("wrdm_idle");
      check("wrdm_drained", wr_q.size() + tx_q.size(), 0);

      // Invalid opcode.
`ifdef LOADER_ACK_EN
      tx_q.push_back(8'hEE);
`endif
      send_byte(8'h09);
      wait_idle("bad_idle");
      check("bad_err", {31'd0, status[7]}, 1);
      check("bad_state", {28'd0, status[3:0]}, 0);
      check("bad_drained", tx_q.size(), 0);

      // Reset in the middle of a four-word read.
      begin
         int base = tx_cnt;
         int n = 0;
         for (int i = 0; i < 4; i++) begin
            tx_q.push_back(mem[11'h030 + 11'(i)][7:0]);
            tx_q.push_back(mem[11'h030 + 11'(i)][15:8]);
         end
         send_byte(8'h04); send_byte(8'h30); send_byte(8'h00); send_byte(8'h03);
         while (tx_cnt < base + 2 && n < 500) begin
            @(negedge clk);
            n++;
         end
         check("mid_reached", {31'd0, (tx_cnt >= base + 2)}, 1);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("mid_tx_start", {31'd0, tx_start}, 0);
      check("mid_bip_reset", {31'd0, bip_reset}, 1);
      check("mid_status", {24'd0, status}, 0);
      tx_q.delete();
      begin
         int n = 0;
         while (tx_pending && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      tx_q.push_back(8'hEF); tx_q.push_back(8'hBE);
      send_byte(8'h04); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
      wait_idle("post_idle");
      check("post_drained", tx_q.size(), 0);
      check("post_err", {31'd0, status[7]}, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
